// File: rtl/axi4_lite_regfile_slave.sv
// AXI4-Lite slave with NUM_REGS byte-strobed registers, SLVERR on out-of-range addresses,
// and the register contents plus a per-register write pulse exported to local logic.
module axi4_lite_regfile_slave #(
   parameter int                    DATA_WIDTH  = 32,
   parameter int                    ADDRESS     = 32,
   parameter int                    NUM_REGS    = 8,
   parameter logic [NUM_REGS-1:0]   RO_MASK     = '0,
   parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic                           ACLK,
   input  logic                           ARESETN,
   input  logic [ADDRESS-1:0]             S_AWADDR,
   input  logic                           S_AWVALID,
   output logic                           S_AWREADY,
   input  logic [DATA_WIDTH-1:0]          S_WDATA,
   input  logic [DATA_WIDTH/8-1:0]        S_WSTRB,
   input  logic                           S_WVALID,
   output logic                           S_WREADY,
   output logic [1:0]                     S_BRESP,
   output logic                           S_BVALID,
   input  logic                           S_BREADY,
   input  logic [ADDRESS-1:0]             S_ARADDR,
   input  logic                           S_ARVALID,
   output logic                           S_ARREADY,
   output logic [DATA_WIDTH-1:0]          S_RDATA,
   output logic [1:0]                     S_RRESP,
   output logic                           S_RVALID,
   input  logic                           S_RREADY,
   output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
   output logic [NUM_REGS-1:0]            wr_pulse
);

   localparam int STRB_W = DATA_WIDTH / 8;
   localparam int LSB    = $clog2(STRB_W);
   localparam int IDX_W  = ADDRESS - LSB;

   logic                  aw_held;
   logic                  w_held;
   logic [IDX_W-1:0]      aw_idx;
   logic [DATA_WIDTH-1:0] w_data;
   logic [STRB_W-1:0]     w_strb;
   logic [DATA_WIDTH-1:0] regs [NUM_REGS];
   logic [IDX_W-1:0]      rd_idx;
   logic                  wr_in_range;
   logic                  rd_in_range;
   logic                  commit;
   logic [DATA_WIDTH-1:0] rd_val;
   logic                  addr_lsb_unused;

   assign S_AWREADY   = !aw_held;
   assign S_WREADY    = !w_held;
   assign S_ARREADY   = !S_RVALID;
   assign rd_idx      = S_ARADDR[ADDRESS-1:LSB];
   assign wr_in_range = aw_idx < IDX_W'(NUM_REGS);
   assign rd_in_range = rd_idx < IDX_W'(NUM_REGS);
   assign commit      = aw_held && w_held && !S_BVALID;

   // Byte-offset address bits carry no meaning for whole-register access.
   assign addr_lsb_unused = ^{S_AWADDR[LSB-1:0], S_ARADDR[LSB-1:0]};

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
      assign reg_q[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
   end

   // Out-of-range indices match no register, so the mux naturally yields zero for them.
   always_comb begin
      rd_val = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (rd_idx == IDX_W'(i)) rd_val = regs[i];
      end
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         aw_held  <= 1'b0;
         w_held   <= 1'b0;
         aw_idx   <= '0;
         w_data   <= '0;
         w_strb   <= '0;
         S_BVALID <= 1'b0;
         S_BRESP  <= 2'b00;
         wr_pulse <= '0;
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VALUE;
      end else begin
         wr_pulse <= '0;
         if (S_AWVALID && !aw_held) begin
            aw_held <= 1'b1;
            aw_idx  <= S_AWADDR[ADDRESS-1:LSB];
         end
         if (S_WVALID && !w_held) begin
            w_held <= 1'b1;
            w_data <= S_WDATA;
            w_strb <= S_WSTRB;
         end
         if (S_BVALID && S_BREADY) S_BVALID <= 1'b0;
         // Commit only while B is free; a held AW/W pair waits out a stalled response.
         if (commit) begin
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            S_BVALID <= 1'b1;
            S_BRESP  <= wr_in_range ? 2'b00 : 2'b10;
            for (int i = 0; i < NUM_REGS; i++) begin
               if (aw_idx == IDX_W'(i) && !RO_MASK[i]) begin
                  wr_pulse[i] <= 1'b1;
                  for (int k = 0; k < STRB_W; k++) begin
                     if (w_strb[k]) regs[i][k*8 +: 8] <= w_data[k*8 +: 8];
                  end
               end
            end
         end
      end
   end

   // Read data is captured at the AR handshake, so a same-edge write returns the old value.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         S_RVALID <= 1'b0;
         S_RDATA  <= '0;
         S_RRESP  <= 2'b00;
      end else if (S_ARVALID && !S_RVALID) begin
         S_RVALID <= 1'b1;
         S_RDATA  <= rd_val;
         S_RRESP  <= rd_in_range ? 2'b00 : 2'b10;
      end else if (S_RVALID && S_RREADY) begin
         S_RVALID <= 1'b0;
      end
   end

endmodule

// File: tb/tb_axi4_lite_regfile_slave.sv
// Directed testbench for axi4_lite_regfile_slave: 8 x 32-bit registers with register 7 read-only.
module tb_axi4_lite_regfile_slave;

   logic         aclk;
   logic         aresetn;
   logic [31:0]  awaddr;
   logic         awvalid;
   logic         awready;
   logic [31:0]  wdata;
   logic [3:0]   wstrb;
   logic         wvalid;
   logic         wready;
   logic [1:0]   bresp;
   logic         bvalid;
   logic         bready;
   logic [31:0]  araddr;
   logic         arvalid;
   logic         arready;
   logic [31:0]  rdata;
   logic [1:0]   rresp;
   logic         rvalid;
   logic         rready;
   logic [255:0] reg_q;
   logic [7:0]   wr_pulse;

   int checks = 0;
   int fails  = 0;

   axi4_lite_regfile_slave #(
      .DATA_WIDTH(32), .ADDRESS(32), .NUM_REGS(8), .RO_MASK(8'h80), .RESET_VALUE(32'h0)
   ) dut (
      .ACLK(aclk), .ARESETN(aresetn),
      .S_AWADDR(awaddr), .S_AWVALID(awvalid), .S_AWREADY(awready),
      .S_WDATA(wdata), .S_WSTRB(wstrb), .S_WVALID(wvalid), .S_WREADY(wready),
      .S_BRESP(bresp), .S_BVALID(bvalid), .S_BREADY(bready),
      .S_ARADDR(araddr), .S_ARVALID(arvalid), .S_ARREADY(arready),
      .S_RDATA(rdata), .S_RRESP(rresp), .S_RVALID(rvalid), .S_RREADY(rready),
      .reg_q(reg_q), .wr_pulse(wr_pulse)
   );

   initial begin
      aclk = 1'b0;
      forever #5 aclk = ~aclk;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [31:0] reg_of(input int i);
      return reg_q[i*32 +: 32];
   endfunction

   // Issues AW and W together and returns the number of cycles from handshake to BVALID.
   task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           output int lat);
      int n;
      awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
      n = 0;
      while (!(awready && wready) && n < 20) begin @(negedge aclk); n++; end
      @(negedge aclk);
      awvalid = 1'b0; wvalid = 1'b0;
      lat = 1;
      while (!bvalid && lat < 20) begin @(negedge aclk); lat++; end
   endtask

   // Reads one address, holding RREADY low for a cycle to observe that R stays stable.
   task automatic do_read(input logic [31:0] a, output logic ok, output logic [31:0] d,
                          output logic [1:0] r, output logic stable);
      int n;
      araddr = a; arvalid = 1'b1; rready = 1'b0;
      n = 0;
      while (!arready && n < 20) begin @(negedge aclk); n++; end
      @(negedge aclk);
      arvalid = 1'b0;
      ok = rvalid; d = rdata; r = rresp;
      @(negedge aclk);
      stable = rvalid && (rdata === d) && (rresp === r);
      rready = 1'b1;
      @(negedge aclk);
      rready = 1'b0;
   endtask

   task automatic test_reset();
      logic ok, st;
      logic [31:0] d;
      logic [1:0] r;
      aresetn = 1'b0;
      repeat (3) @(negedge aclk);
      aresetn = 1'b1;
      @(negedge aclk);
      checks++;
      if ({awready, wready, arready} !== 3'b111) begin
         fails++; $display("[TB] FAIL reset_ready: got %b expected 111", {awready, wready, arready});
      end
      checks++;
      if ({bvalid, rvalid} !== 2'b00) begin
         fails++; $display("[TB] FAIL reset_valid: got %b expected 00", {bvalid, rvalid});
      end
      checks++;
      if (reg_q !== 256'h0) begin
         fails++; $display("[TB] FAIL reset_regs: got %h expected 0", reg_q);
      end
      checks++;
      if (wr_pulse !== 8'h00) begin
         fails++; $display("[TB] FAIL reset_pulse: got %h expected 00", wr_pulse);
      end
      do_read(32'h1C, ok, d, r, st);
      checks++;
      if (ok !== 1'b1 || d !== 32'h0 || r !== 2'b00) begin
         fails++; $display("[TB] FAIL reset_read: got valid=%b data=%h resp=%b expected 1/0/00", ok, d, r);
      end
   endtask

   task automatic test_write_same_cycle();
      int lat;
      logic ok, st;
      logic [31:0] d;
      logic [1:0] r;
      do_write(32'h04, 32'hDEADBEEF, 4'hF, lat);
      checks++;
      if (lat !== 2) begin
         fails++; $display("[TB] FAIL write_latency: got %0d expected 2", lat);
      end
      checks++;
      if (bresp !== 2'b00 || wr_pulse !== 8'h02 || reg_of(1) !== 32'hDEADBEEF) begin
         fails++; $display("[TB] FAIL write_commit: got resp=%b pulse=%h reg1=%h expected 00/02/deadbeef",
                           bresp, wr_pulse, reg_of(1));
      end
      @(negedge aclk);
      checks++;
      if (bvalid !== 1'b0 || wr_pulse !== 8'h00) begin
         fails++; $display("[TB] FAIL write_b_clear: got bvalid=%b pulse=%h expected 0/00", bvalid, wr_pulse);
      end
      do_read(32'h04, ok, d, r, st);
      checks++;
      if (ok !== 1'b1 || d !== 32'hDEADBEEF || r !== 2'b00) begin
         fails++; $display("[TB] FAIL read_back: got valid=%b data=%h resp=%b expected 1/deadbeef/00", ok, d, r);
      end
      checks++;
      if (st !== 1'b1) begin
         fails++; $display("[TB] FAIL read_stable: got %b expected 1", st);
      end
   endtask

   task automatic test_w_before_aw();
      wdata = 32'h12345678; wstrb = 4'h3; wvalid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge aclk);
         if (k == 0) wvalid = 1'b0;
         checks++;
         if (wready !== 1'b0 || awready !== 1'b1 || bvalid !== 1'b0) begin
            fails++; $display("[TB] FAIL w_held_%0d: got wready=%b awready=%b bvalid=%b expected 0/1/0",
                              k, wready, awready, bvalid);
         end
      end
      awaddr = 32'h05; awvalid = 1'b1;
      @(negedge aclk);
      awvalid = 1'b0;
      checks++;
      if (bvalid !== 1'b0) begin
         fails++; $display("[TB] FAIL w_first_early_b: got %b expected 0", bvalid);
      end
      @(negedge aclk);
      checks++;
      if (bvalid !== 1'b1 || bresp !== 2'b00 || wr_pulse !== 8'h02 || reg_of(1) !== 32'hDEAD5678) begin
         fails++; $display("[TB] FAIL w_first_commit: got bvalid=%b resp=%b pulse=%h reg1=%h expected 1/00/02/dead5678",
                           bvalid, bresp, wr_pulse, reg_of(1));
      end
      @(negedge aclk);
      checks++;
      if (bvalid !== 1'b0 || wready !== 1'b1) begin
         fails++; $display("[TB] FAIL w_first_release: got bvalid=%b wready=%b expected 0/1", bvalid, wready);
      end
   endtask

   task automatic test_out_of_range_and_ro();
      int lat;
      logic ok, st;
      logic [31:0] d;
      logic [1:0] r;
      logic [255:0] expected;
      expected = '0;
      expected[63:32] = 32'hDEAD5678;
      do_write(32'h20, 32'hA5A5A5A5, 4'hF, lat);
      checks++;
      if (lat !== 2 || bresp !== 2'b10 || wr_pulse !== 8'h00 || reg_q !== expected) begin
         fails++; $display("[TB] FAIL oor_write: got lat=%0d resp=%b pulse=%h regs=%h expected 2/10/00/%h",
                           lat, bresp, wr_pulse, reg_q, expected);
      end
      @(negedge aclk);
      do_read(32'h20, ok, d, r, st);
      checks++;
      if (ok !== 1'b1 || d !== 32'h0 || r !== 2'b10 || st !== 1'b1) begin
         fails++; $display("[TB] FAIL oor_read: got valid=%b data=%h resp=%b stable=%b expected 1/0/10/1",
                           ok, d, r, st);
      end
      do_write(32'h1C, 32'hFFFFFFFF, 4'hF, lat);
      checks++;
      if (lat !== 2 || bresp !== 2'b00 || wr_pulse !== 8'h00 || reg_of(7) !== 32'h0) begin
         fails++; $display("[TB] FAIL ro_write: got lat=%0d resp=%b pulse=%h reg7=%h expected 2/00/00/0",
                           lat, bresp, wr_pulse, reg_of(7));
      end
      @(negedge aclk);
   endtask

   task automatic test_back_to_back();
      int lat;
      bready = 1'b0;
      do_write(32'h0C, 32'hCAFEF00D, 4'hF, lat);
      checks++;
      if (lat !== 2 || bresp !== 2'b00) begin
         fails++; $display("[TB] FAIL b2b_first: got lat=%0d resp=%b expected 2/00", lat, bresp);
      end
      awaddr = 32'h08; wdata = 32'h55AA55AA; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
      @(negedge aclk);
      awvalid = 1'b0; wvalid = 1'b0;
      checks++;
      if ({awready, wready, bvalid} !== 3'b001 || bresp !== 2'b00) begin
         fails++; $display("[TB] FAIL b2b_capture: got aw/w/b=%b resp=%b expected 001/00",
                           {awready, wready, bvalid}, bresp);
      end
      for (int k = 0; k < 3; k++) begin
         @(negedge aclk);
         checks++;
         if (bvalid !== 1'b1 || bresp !== 2'b00 || reg_of(2) !== 32'h0) begin
            fails++; $display("[TB] FAIL b2b_hold_%0d: got bvalid=%b resp=%b reg2=%h expected 1/00/0",
                              k, bvalid, bresp, reg_of(2));
         end
      end
      bready = 1'b1;
      @(negedge aclk);
      checks++;
      if (bvalid !== 1'b0 || reg_of(2) !== 32'h0) begin
         fails++; $display("[TB] FAIL b2b_gap: got bvalid=%b reg2=%h expected 0/0", bvalid, reg_of(2));
      end
      @(negedge aclk);
      checks++;
      if (bvalid !== 1'b1 || wr_pulse !== 8'h04 || reg_of(2) !== 32'h55AA55AA || reg_of(3) !== 32'hCAFEF00D) begin
         fails++; $display("[TB] FAIL b2b_second: got bvalid=%b pulse=%h reg2=%h reg3=%h expected 1/04/55aa55aa/cafef00d",
                           bvalid, wr_pulse, reg_of(2), reg_of(3));
      end
      @(negedge aclk);
   endtask

   task automatic test_reset_mid_flight();
      int lat;
      bready = 1'b0; rready = 1'b0;
      do_write(32'h00, 32'h0BADF00D, 4'hF, lat);
      araddr = 32'h0C; arvalid = 1'b1;
      @(negedge aclk);
      arvalid = 1'b0;
      checks++;
      if ({bvalid, rvalid} !== 2'b11 || reg_of(0) !== 32'h0BADF00D || rdata !== 32'hCAFEF00D) begin
         fails++; $display("[TB] FAIL mid_setup: got b/r=%b reg0=%h rdata=%h expected 11/0badf00d/cafef00d",
                           {bvalid, rvalid}, reg_of(0), rdata);
      end
      #2 aresetn = 1'b0;
      #1;
      checks++;
      if ({bvalid, rvalid} !== 2'b00 || reg_q !== 256'h0 || rdata !== 32'h0) begin
         fails++; $display("[TB] FAIL mid_reset: got b/r=%b regs=%h rdata=%h expected 00/0/0",
                           {bvalid, rvalid}, reg_q, rdata);
      end
      @(negedge aclk);
      aresetn = 1'b1; bready = 1'b1; rready = 1'b1;
      repeat (2) @(negedge aclk);
      checks++;
      if ({bvalid, rvalid} !== 2'b00 || {awready, wready, arready} !== 3'b111 || reg_q !== 256'h0) begin
         fails++; $display("[TB] FAIL mid_release: got b/r=%b ready=%b regs=%h expected 00/111/0",
                           {bvalid, rvalid}, {awready, wready, arready}, reg_q);
      end
   endtask

   initial begin
      aresetn = 1'b0;
      awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b1;
      araddr = '0; arvalid = 1'b0; rready = 1'b0;
      test_reset();
      test_write_same_cycle();
      test_w_before_aw();
      test_out_of_range_and_ro();
      test_back_to_back();
      test_reset_mid_flight();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
